// File: rtl/reg_demux_guard.sv
// Shared register-bus and address-rule types. The widths here match the
// default AddrWidth/DataWidth of reg_demux_guard. A design that changes those
// widths must also pass matching rule_t/req_t/rsp_t/addr_t types.
package reg_demux_guard_pkg;

    typedef logic [31:0] addr_t;

    typedef struct packed {
        logic [31:0] idx;
        addr_t       start_addr;
        addr_t       end_addr;
    } rule_t;

    typedef struct packed {
        addr_t       addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } rsp_t;

endpackage

// Purpose: reg-bus demux with address decode, local error responder, per-transaction watchdog.
// Latency: mapped access = 1 cycle decode + k FWD cycles + 1 RESP cycle; local errors answer in 1 cycle.
// Backpressure: one transaction in flight; requests are only accepted in IDLE and held by upstream until ready.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   addr_map_i             address rules {idx, start_addr, end_addr}, end exclusive, lowest rule wins
//   in_req_i / in_rsp_o    upstream request / response
//   out_req_o / out_rsp_i  per-port downstream requests / responses
//   hung_clear_i, hung_o   per-port sticky hung flags and their level clears
//   timeout_o              one-cycle pulse on each watchdog expiry
//   err_cnt_clear_i        clears the local-error counter
//   err_cnt_o              saturating count of locally generated errors
//   busy_o                 high whenever a transaction is in progress
module reg_demux_guard #(
    parameter int unsigned          NoPorts       = 4,
    parameter int unsigned          NoRules       = NoPorts,
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          TimeoutCycles = 256,
    parameter logic [DataWidth-1:0] ErrData       = 32'hBADC_AB1E,
    parameter int unsigned          CntWidth      = 16,
    parameter type                  rule_t        = reg_demux_guard_pkg::rule_t,
    parameter type                  req_t         = reg_demux_guard_pkg::req_t,
    parameter type                  rsp_t         = reg_demux_guard_pkg::rsp_t,
    parameter type                  addr_t        = reg_demux_guard_pkg::addr_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  rule_t               addr_map_i [NoRules],
    input  req_t                in_req_i,
    output rsp_t                in_rsp_o,
    output req_t                out_req_o  [NoPorts],
    input  rsp_t                out_rsp_i  [NoPorts],
    input  logic [NoPorts-1:0]  hung_clear_i,
    output logic [NoPorts-1:0]  hung_o,
    output logic                timeout_o,
    input  logic                err_cnt_clear_i,
    output logic [CntWidth-1:0] err_cnt_o,
    output logic                busy_o
);

    localparam int unsigned SelW  = (NoPorts > 1) ? $clog2(NoPorts) : 1;
    localparam int unsigned WdW   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam int unsigned StrbW = DataWidth / 8;
    // Last watchdog count before expiry; meaningless (and unused) when the watchdog is off.
    localparam logic [WdW-1:0] WdLast = WdW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam bit             WdOn   = (TimeoutCycles != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state;
    addr_t                lat_addr;
    logic                 lat_write;
    logic [DataWidth-1:0] lat_wdata;
    logic [StrbW-1:0]     lat_wstrb;
    logic [SelW-1:0]      sel;
    logic [DataWidth-1:0] rsp_rdata;
    logic                 rsp_error;
    logic [WdW-1:0]       wd;
    logic [NoPorts-1:0]   hung;
    logic [CntWidth-1:0]  err_cnt;

    // ------------------------------------------------------------------
    // Address decode. Rules are scanned from the highest index down so the
    // lowest-index match is the one left standing. A matching rule whose
    // port index is out of range makes the address unmapped rather than
    // letting a later rule take over.
    // ------------------------------------------------------------------
    logic            dec_hit;
    logic [SelW-1:0] dec_sel;

    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int r = int'(NoRules) - 1; r >= 0; r--) begin
            if ((in_req_i.addr >= addr_map_i[r].start_addr) &&
                (in_req_i.addr <  addr_map_i[r].end_addr)) begin
                dec_hit = (addr_map_i[r].idx < NoPorts);
                dec_sel = SelW'(addr_map_i[r].idx);
            end
        end
    end

    // A port already marked hung is answered locally instead of forwarded.
    logic dec_err;
    assign dec_err = !dec_hit || hung[dec_sel];

    // ------------------------------------------------------------------
    // Watchdog expiry: only when the slave is not ready in the final count,
    // so a ready arriving in the expiry cycle still completes normally.
    // ------------------------------------------------------------------
    logic sel_ready;
    logic expiry;

    assign sel_ready = out_rsp_i[sel].ready;
    assign expiry    = WdOn && (state == ST_FWD) && !sel_ready && (wd == WdLast);

    logic local_err;
    assign local_err = ((state == ST_IDLE) && in_req_i.valid && dec_err) || expiry;

    logic [NoPorts-1:0] hung_set;
    always_comb begin
        hung_set = '0;
        for (int p = 0; p < int'(NoPorts); p++) begin
            if (expiry && (SelW'(p) == sel)) begin
                hung_set[p] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            sel       <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            wd        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_req_i.valid) begin
                        lat_addr  <= in_req_i.addr;
                        lat_write <= in_req_i.write;
                        lat_wdata <= in_req_i.wdata;
                        lat_wstrb <= in_req_i.wstrb;
                        sel       <= dec_sel;
                        wd        <= '0;
                        if (dec_err) begin
                            rsp_rdata <= ErrData;
                            rsp_error <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            state     <= ST_FWD;
                        end
                    end
                end
                ST_FWD: begin
                    if (sel_ready) begin
                        rsp_rdata <= out_rsp_i[sel].rdata;
                        rsp_error <= out_rsp_i[sel].error;
                        state     <= ST_RESP;
                    end else if (expiry) begin
                        rsp_rdata <= ErrData;
                        rsp_error <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky hung flags (set beats clear on the same port) and the
    // saturating local-error counter (a coinciding increment survives a clear).
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hung    <= '0;
            err_cnt <= '0;
        end else begin
            hung <= (hung & ~hung_clear_i) | hung_set;
            if (err_cnt_clear_i) begin
                err_cnt <= local_err ? CntWidth'(1) : '0;
            end else if (local_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: everything is zero unless the owning state drives it.
    // ------------------------------------------------------------------
    always_comb begin
        in_rsp_o = '0;
        if (state == ST_RESP) begin
            in_rsp_o.ready = 1'b1;
            in_rsp_o.rdata = rsp_rdata;
            in_rsp_o.error = rsp_error;
        end
    end

    always_comb begin
        for (int p = 0; p < int'(NoPorts); p++) begin
            out_req_o[p] = '0;
            if ((state == ST_FWD) && (SelW'(p) == sel)) begin
                out_req_o[p].addr  = lat_addr;
                out_req_o[p].write = lat_write;
                out_req_o[p].wdata = lat_wdata;
                out_req_o[p].wstrb = lat_wstrb;
                out_req_o[p].valid = 1'b1;
            end
        end
    end

    assign hung_o    = hung;
    assign timeout_o = expiry;
    assign err_cnt_o = err_cnt;
    assign busy_o    = (state != ST_IDLE);

endmodule
